// File: rtl/gnrl_rr_arb_stage.sv
// gnrl_rr_arb_stage
// N-to-1 round-robin arbiter with a single-entry registered output stage.
// Several valid/ready requesters share one downstream valid/ready pipe.
// A requester that presents i_lck=1 with an accepted beat keeps the port
// until it delivers a beat with i_lck=0 (burst locking).
// Latency is one cycle. A beat can drain and a new beat can load in the
// same cycle, so the stage sustains one beat per cycle.
//
// state           | meaning
// ----------------+-------------------------------------------------------
// o_vld_q=0       | output slot empty, any grant can load it
// o_vld_q=1       | beat held in output slot, waiting for o_rdy
// locked_q=0      | round-robin scan starts at ptr_q
// locked_q=1      | port reserved for lck_id_q until its last beat

module gnrl_rr_arb_stage #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_vld,
    output logic [N-1:0]    i_rdy,
    input  logic [N*DW-1:0] i_dat,
    input  logic [N-1:0]    i_lck,
    output logic            o_vld,
    input  logic            o_rdy,
    output logic [DW-1:0]   o_dat,
    output logic [IW-1:0]   o_id
);

    // registered state and its next-state values
    logic          o_vld_q,  o_vld_d;
    logic [DW-1:0] o_dat_q,  o_dat_d;
    logic [IW-1:0] o_id_q,   o_id_d;
    logic [IW-1:0] ptr_q,    ptr_d;
    logic          locked_q, locked_d;
    logic [IW-1:0] lck_id_q, lck_id_d;

    // combinational grant path
    logic          slot_free;
    logic [IW-1:0] gnt_idx;
    logic          acc;
    logic [DW-1:0] sel_dat;
    logic [IW-1:0] ptr_nxt;

    // The slot can take a new beat when it is empty or being drained now.
    assign slot_free = ~o_vld_q | o_rdy;

    // Pick the requester: the lock holder while locked, otherwise the first
    // valid requester at or after ptr_q (circularly). With nothing valid the
    // grant rests on ptr_q so i_rdy still advertises who would be served.
    always_comb begin
        logic          found;
        int            idx;
        logic [IW-1:0] idx_l;
        found   = 1'b0;
        idx     = 0;
        idx_l   = '0;
        gnt_idx = ptr_q;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_l = IW'(idx);
            if (!found && i_vld[idx_l]) begin
                found   = 1'b1;
                gnt_idx = idx_l;
            end
        end
        if (locked_q) begin
            gnt_idx = lck_id_q;
        end
    end

    // Ready goes only to the granted requester, and only when the slot is free.
    // A locked holder keeps ready even with its valid low, so nobody steals
    // the port mid-burst.
    always_comb begin
        i_rdy = '0;
        if (slot_free) begin
            i_rdy[gnt_idx] = 1'b1;
        end
    end

    assign acc = slot_free & i_vld[gnt_idx];

    // Route the granted requester's payload toward the output register.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == IW'(k)) begin
                sel_dat = i_dat[k*DW +: DW];
            end
        end
    end

    // Round-robin successor of the winner; explicit wrap keeps this correct
    // when N is not a power of two.
    assign ptr_nxt = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

    // Next-state: load on accept, clear valid on a drain without a new beat,
    // otherwise hold (this also covers the stall case).
    always_comb begin
        o_vld_d  = o_vld_q;
        o_dat_d  = o_dat_q;
        o_id_d   = o_id_q;
        ptr_d    = ptr_q;
        locked_d = locked_q;
        lck_id_d = lck_id_q;
        if (acc) begin
            o_vld_d = 1'b1;
            o_dat_d = sel_dat;
            o_id_d  = gnt_idx;
            if (i_lck[gnt_idx]) begin
                locked_d = 1'b1;
                lck_id_d = gnt_idx;
            end else begin
                locked_d = 1'b0;
                ptr_d    = ptr_nxt;
            end
        end else if (o_rdy) begin
            o_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any held beat and lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q  <= 1'b0;
            o_dat_q  <= '0;
            o_id_q   <= '0;
            ptr_q    <= '0;
            locked_q <= 1'b0;
            lck_id_q <= '0;
        end else begin
            o_vld_q  <= o_vld_d;
            o_dat_q  <= o_dat_d;
            o_id_q   <= o_id_d;
            ptr_q    <= ptr_d;
            locked_q <= locked_d;
            lck_id_q <= lck_id_d;
        end
    end

    assign o_vld = o_vld_q;
    assign o_dat = o_dat_q;
    assign o_id  = o_id_q;

endmodule

// File: tb/tb_gnrl_rr_arb_stage.sv
// Directed bench for gnrl_rr_arb_stage (N=4, DW=32).
// Each vector row is one clock: inputs are applied, i_rdy is checked before
// the edge, and the registered outputs are checked just after it.
// Requester k payload is base+k, with base chosen per row.

module tb_gnrl_rr_arb_stage;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    i_vld = '0;
    logic [N-1:0]    i_rdy;
    logic [N*DW-1:0] i_dat = '0;
    logic [N-1:0]    i_lck = '0;
    logic            o_vld;
    logic            o_rdy = 1'b0;
    logic [DW-1:0]   o_dat;
    logic [IW-1:0]   o_id;

    int n_total = 0;
    int n_pass  = 0;

    gnrl_rr_arb_stage #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_vld (i_vld),
        .i_rdy (i_rdy),
        .i_dat (i_dat),
        .i_lck (i_lck),
        .o_vld (o_vld),
        .o_rdy (o_rdy),
        .o_dat (o_dat),
        .o_id  (o_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [3:0]    vld;
        logic [3:0]    lck;
        logic          ordy;
        logic [31:0]   base;
        logic          chk_rdy;
        logic [3:0]    exp_rdy;
        logic          exp_vld;
        logic [1:0]    exp_id;
        logic [31:0]   exp_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic ordy,
                                logic [31:0] base, logic cr, logic [3:0] erdy,
                                logic evld, logic [1:0] eid, logic [31:0] edat);
        vec_t t;
        t.rst = r; t.vld = v; t.lck = l; t.ordy = ordy; t.base = base;
        t.chk_rdy = cr; t.exp_rdy = erdy; t.exp_vld = evld; t.exp_id = eid;
        t.exp_dat = edat;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic ordy, input logic [31:0] base);
        rst   = r;
        i_vld = v;
        i_lck = l;
        o_rdy = ordy;
        for (int k = 0; k < N; k++) begin
            i_dat[k*DW +: DW] = base + 32'(k);
        end
    endtask

    initial begin
        //          rst vld      lck      ordy base      chk rdy      vld id dat
        // reset and idle
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 32'hA0, 0, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hA0, 1, 4'b0001, 0, 0, 32'h0));
        // all requesters valid: strict rotation, no bubbles
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b0001, 1, 0, 32'hA0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b0010, 1, 1, 32'hA1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b0100, 1, 2, 32'hA2));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b1000, 1, 3, 32'hA3));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b0001, 1, 0, 32'hA0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b0010, 1, 1, 32'hA1));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b0100, 1, 2, 32'hA2));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 32'hA0, 1, 4'b1000, 1, 3, 32'hA3));
        // drain with nothing new: valid drops, data and id hold
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hA0, 1, 4'b0001, 0, 3, 32'hA3));
        // requester 2 alone, then a 3-cycle stall with changing input data
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 32'hB0, 1, 4'b0100, 1, 2, 32'hB2));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 32'hC0, 1, 4'b0000, 1, 2, 32'hB2));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 32'hC0, 1, 4'b0000, 1, 2, 32'hB2));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 32'hC0, 1, 4'b0000, 1, 2, 32'hB2));
        // release: drain and accept the next beat of requester 2 together
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 32'hC0, 1, 4'b0100, 1, 2, 32'hC2));
        // ptr=3: grant 3, wrap to 0, then idle shows ptr=1
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 32'hD0, 1, 4'b1000, 1, 3, 32'hD3));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 32'hD0, 1, 4'b0001, 1, 0, 32'hD0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 32'hD0, 1, 4'b0010, 0, 0, 32'hD0));
        // burst from requester 1 with 0 and 3 contending, one-cycle gap mid-burst
        vecs.push_back(mk(0, 4'b1011, 4'b0010, 1, 32'hE0, 1, 4'b0010, 1, 1, 32'hE1));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 32'hE0, 1, 4'b0010, 0, 1, 32'hE1));
        vecs.push_back(mk(0, 4'b1011, 4'b0010, 1, 32'hF0, 1, 4'b0010, 1, 1, 32'hF1));
        vecs.push_back(mk(0, 4'b1011, 4'b0000, 1, 32'h10, 1, 4'b0010, 1, 1, 32'h11));
        // burst done: ptr=2, scan 2,3 -> requester 3
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 1, 32'h20, 1, 4'b1000, 1, 3, 32'h23));
        // lock requester 2, stall, then reset while locked and holding a beat
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 32'h30, 1, 4'b0100, 1, 2, 32'h32));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 0, 32'h40, 1, 4'b0000, 1, 2, 32'h32));
        vecs.push_back(mk(1, 4'b0100, 4'b0100, 0, 32'h40, 1, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h40, 1, 4'b0001, 0, 0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].lck, vecs[i].ordy, vecs[i].base);
            #1;
            if (vecs[i].chk_rdy) begin
                chk("i_rdy", i, 32'(i_rdy), 32'(vecs[i].exp_rdy));
            end
            @(posedge clk);
            #1;
            chk("o_vld", i, 32'(o_vld), 32'(vecs[i].exp_vld));
            chk("o_id",  i, 32'(o_id),  32'(vecs[i].exp_id));
            chk("o_dat", i, o_dat, vecs[i].exp_dat);
        end

        // Lock held indefinitely by requester 0 while everyone is valid: the
        // others are starved by design, every beat must come from 0.
        for (int c = 0; c < 6; c++) begin
            drive(0, 4'b1111, 4'b0001, 1, 32'h50 + 32'(c * 16));
            #1;
            chk("hold_rdy", 100 + c, 32'(i_rdy), 32'h1);
            @(posedge clk);
            #1;
            chk("hold_vld", 100 + c, 32'(o_vld), 32'h1);
            chk("hold_id",  100 + c, 32'(o_id),  32'h0);
            chk("hold_dat", 100 + c, o_dat, 32'h50 + 32'(c * 16));
        end
        // last beat of the burst, then rotation resumes at requester 1
        drive(0, 4'b1111, 4'b0000, 1, 32'hB0);
        @(posedge clk);
        #1;
        chk("last_id", 106, 32'(o_id), 32'h0);
        chk("last_dat", 106, o_dat, 32'hB0);
        drive(0, 4'b1111, 4'b0000, 1, 32'hC0);
        #1;
        chk("next_rdy", 107, 32'(i_rdy), 32'h2);
        @(posedge clk);
        #1;
        chk("next_id", 107, 32'(o_id), 32'h1);
        chk("next_dat", 107, o_dat, 32'hC1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gnrl_rr_arb_stage.md
Name: gnrl_rr_arb_stage

Overview:
- N-to-1 round-robin arbiter fused with a single-entry registered output stage.
- Shares one downstream valid/ready pipe among N upstream valid/ready requesters, e.g. LSU and fetch sharing one memory command port.
- Supports burst locking, so a multi-beat requester keeps the port until its last beat.
- Latency is one cycle. Throughput is one beat per cycle.

Parameters:
- N, 4: number of requesters; N >= 2; need not be a power of two.
- DW, 32: payload width per requester.
- IW, 2: width of the granted-requester index; must equal ceil(log2(N)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active high.
- i_vld  in  N  per-requester valid.
- i_rdy  out  N  per-requester ready; at most one bit high per cycle.
- i_dat  in  N*DW  payloads; requester k occupies bits [k*DW +: DW].
- i_lck  in  N  burst lock, sampled with each accepted beat; 1 means more beats follow.
- o_vld  out  1  output valid (registered).
- o_rdy  in  1  downstream ready.
- o_dat  out  DW  output payload (registered).
- o_id  out  IW  index of the requester that supplied o_dat (registered).

Behaviour:
- Reset (rst=1 at a rising edge):
  - o_vld=0, o_dat=0, o_id=0.
  - Round-robin pointer ptr=0, locked=0, lck_id=0.
  - Reset mid-burst or mid-stall discards the held beat and any lock.
- Slot free: slot_free = ~o_vld | o_rdy.
- Grant (combinational from i_vld, ptr, locked, lck_id, slot_free):
  - If slot_free=0: all i_rdy=0.
  - If locked=1: i_rdy[lck_id] = slot_free. All other i_rdy=0, even if lck_id has i_vld=0 (no stealing mid-burst).
  - Otherwise: grant the first k with i_vld[k]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. i_rdy[k] = slot_free. All others 0.
  - i_rdy may be high for the chosen requester whether or not its i_vld is high. Only i_vld & i_rdy counts as a transfer.
- Accept of requester k (i_vld[k] & i_rdy[k]), at the next edge:
  - o_vld=1, o_dat=i_dat[k], o_id=k.
  - If i_lck[k]=1: locked=1, lck_id=k, ptr unchanged.
  - If i_lck[k]=0: locked=0, ptr=(k+1) mod N; wraps from N-1 to 0.
- Output drain without accept (o_vld & o_rdy, no input accepted): o_vld=0. o_dat and o_id hold their values.
- Simultaneous drain and accept: o_vld stays 1 and o_dat/o_id take the new beat, giving back-to-back beats with no bubble.
- Stall (o_vld=1, o_rdy=0):
  - o_vld, o_dat, o_id, ptr and the lock state all hold.
  - i_rdy is all zero.
- No request (no i_vld set, slot free): ptr and the lock state unchanged.
- Payload stability: o_dat is stable while o_vld=1 and o_rdy=0. i_dat need only be valid while i_vld=1.
- Fairness: with all N requesters continuously valid and no locks, grants rotate 0,1,...,N-1,0,... and each requester waits at most N-1 beats.
- Lock hazard: a locked requester that never deasserts i_lck starves the others. This is legal, and the bench must not flag it as a deadlock.

Test Plan:
- Reset, then idle with all i_vld=0 -> o_vld=0, o_id=0, i_rdy=4'b0001 (ptr=0, slot free).
- N=4, i_vld=4'b1111 held for 8 cycles, o_rdy=1, i_dat[k]=32'hA0+k:
  - o_id sequence 0,1,2,3,0,1,2,3 from cycle 1.
  - o_dat 32'hA0,A1,A2,A3,... with o_vld continuously 1.
- Single requester 2 valid, o_rdy=0 for 3 cycles after accept:
  - o_vld=1, o_dat held, i_rdy=0 during the stall.
  - Releasing o_rdy drains the beat, and the next beat of requester 2 is accepted in the same cycle.
- Requester 1 sends 3 beats with i_lck=1,1,0 while requesters 0 and 3 are valid throughout:
  - o_id=1,1,1, then o_id=3 (ptr=2 scans 2,3).
  - Requester 1 deasserting i_vld for one cycle mid-burst -> bubble, no grant to 0 or 3.
- ptr=3 after a grant to 2, i_vld=4'b1001 -> grant 3, then grant 0 (wrap), then ptr=1.
- Reset asserted while locked=1 and o_vld=1, o_rdy=0 -> next cycle o_vld=0, locked=0, ptr=0, i_rdy=4'b0001.
